// File: rtl/cci_mpf_stream_pkg.sv
// Shared types and helpers for the streaming read/increment/write AFU.
package cci_mpf_stream_pkg;

    localparam int LANE_W              = 64;
    localparam int PKG_DATA_W          = 512;
    localparam int NUM_LANES           = PKG_DATA_W / LANE_W;
    localparam int PKG_MAX_OUTSTANDING = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } t_stream_state;

    typedef logic [$clog2(PKG_MAX_OUTSTANDING)-1:0] t_slot_tag;

    // Independent 64-bit adds per lane; carries never cross a lane boundary.
    function automatic logic [PKG_DATA_W-1:0] add_lanes(
        input logic [PKG_DATA_W-1:0] data,
        input logic [LANE_W-1:0]     incr
    );
        logic [PKG_DATA_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sum[i*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W] + incr;
        end
        return sum;
    endfunction

endpackage

// File: rtl/cci_mpf_stream_rsp_fifo.sv
// Synchronous FIFO holding {tag, data} read responses until the write channel can take them.
module cci_mpf_stream_rsp_fifo #(
    parameter int WIDTH = 516,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_not_empty,
    output logic             o_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && o_not_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_not_empty = (r_wr_ptr != r_rd_ptr);
    assign o_full      = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                         (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_pop_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/cci_mpf_stream_incr_afu.sv
// Streams NUM_LINES lines from the host, adds incr to every 64-bit lane and writes each line back.
// Optional CCI_MPF_STREAM_PERF_EN adds busy-cycle and stall-cycle counters.
module cci_mpf_stream_incr_afu
    import cci_mpf_stream_pkg::*;
#(
    parameter int ADDR_W          = 42,
    parameter int DATA_W          = 512,
    parameter int MAX_OUTSTANDING = 16,
    parameter int LEN_W           = 16,
    localparam int TAG_W          = $clog2(MAX_OUTSTANDING)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_lines,
    input  logic [63:0]       incr,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    output logic [TAG_W-1:0]  rd_req_tag,
    input  logic              rd_almfull,
    input  logic              rd_rsp_valid,
    input  logic [TAG_W-1:0]  rd_rsp_tag,
    input  logic [DATA_W-1:0] rd_rsp_data,
    output logic              wr_req_valid,
    output logic [ADDR_W-1:0] wr_req_addr,
    output logic [DATA_W-1:0] wr_req_data,
    input  logic              wr_almfull,
    input  logic              wr_ack_valid,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  lines_done,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall,
    output t_stream_state     dbg_state
);

    // Valid/ready: rd_req_valid/wr_req_valid each carry one request per cycle and are only
    // raised when the matching almfull input was low in the issuing cycle; no ready handshake.

    t_stream_state              r_state;
    t_stream_state              w_state_nxt;
    logic [ADDR_W-1:0]          r_base;
    logic [LEN_W-1:0]           r_num;
    logic [63:0]                r_incr;
    logic [LEN_W-1:0]           r_issued;
    logic [LEN_W-1:0]           r_lines_done;
    logic [MAX_OUTSTANDING-1:0] r_slot_busy;
    logic [MAX_OUTSTANDING-1:0] w_slot_nxt;
    logic [LEN_W-1:0]           r_offset [MAX_OUTSTANDING];

    logic                       r_rd_req_valid;
    logic [ADDR_W-1:0]          r_rd_req_addr;
    logic [TAG_W-1:0]           r_rd_req_tag;
    logic                       r_wr_req_valid;
    logic [ADDR_W-1:0]          r_wr_req_addr;
    logic [DATA_W-1:0]          r_wr_req_data;

    logic                       w_busy;
    logic                       w_start_ok;
    logic [TAG_W-1:0]           w_issue_tag;
    logic                       w_issue;
    logic                       w_rsp_push;
    logic [TAG_W+DATA_W-1:0]    w_fifo_head;
    logic                       w_fifo_not_empty;
    logic                       w_fifo_full;
    logic                       w_pop;
    logic [TAG_W-1:0]           w_pop_tag;
    logic [DATA_W-1:0]          w_pop_data;
    logic [DATA_W-1:0]          w_wr_data;
    logic                       w_ack;

    assign w_busy      = (r_state == RUN) || (r_state == DRAIN);
    assign w_start_ok  = start && !w_busy;
    assign w_issue_tag = r_issued[TAG_W-1:0];
    assign w_issue     = (r_state == RUN) && !rd_almfull &&
                         !r_slot_busy[w_issue_tag] && (r_issued < r_num);
    // Responses for free slots (protocol error) and stale ones outside a run are dropped.
    assign w_rsp_push  = rd_rsp_valid && w_busy && r_slot_busy[rd_rsp_tag];
    assign w_pop       = w_fifo_not_empty && !wr_almfull && w_busy;
    assign w_pop_tag   = w_fifo_head[TAG_W+DATA_W-1 -: TAG_W];
    assign w_pop_data  = w_fifo_head[DATA_W-1:0];
    assign w_wr_data   = DATA_W'(add_lanes(PKG_DATA_W'(w_pop_data), r_incr));
    assign w_ack       = wr_ack_valid && w_busy && (r_lines_done != r_num);

    cci_mpf_stream_rsp_fifo #(
        .WIDTH (TAG_W + DATA_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_rsp_push),
        .i_push_data ({rd_rsp_tag, rd_rsp_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_head),
        .o_not_empty (w_fifo_not_empty),
        .o_full      (w_fifo_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_state_nxt = (num_lines == '0) ? DONE : RUN;
            RUN:        if (r_issued == r_num) w_state_nxt = DRAIN;
            DRAIN:      if (r_lines_done == r_num) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // A popped tag frees its slot for reuse next cycle; an issue never targets a busy slot.
    always_comb begin
        w_slot_nxt = r_slot_busy;
        if (w_pop)   w_slot_nxt[w_pop_tag]   = 1'b0;
        if (w_issue) w_slot_nxt[w_issue_tag] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_issue) r_offset[w_issue_tag] <= r_issued;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_base         <= '0;
            r_num          <= '0;
            r_incr         <= '0;
            r_issued       <= '0;
            r_lines_done   <= '0;
            r_slot_busy    <= '0;
            r_rd_req_valid <= 1'b0;
            r_rd_req_addr  <= '0;
            r_rd_req_tag   <= '0;
            r_wr_req_valid <= 1'b0;
            r_wr_req_addr  <= '0;
            r_wr_req_data  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_slot_busy    <= w_slot_nxt;
            r_rd_req_valid <= w_issue;
            r_wr_req_valid <= w_pop;
            if (w_start_ok) begin
                r_base       <= base_addr;
                r_num        <= num_lines;
                r_incr       <= incr;
                r_issued     <= '0;
                r_lines_done <= '0;
            end
            if (w_issue) begin
                r_issued      <= r_issued + 1'b1;
                r_rd_req_addr <= r_base + ADDR_W'(r_issued);
                r_rd_req_tag  <= w_issue_tag;
            end
            if (w_pop) begin
                r_wr_req_addr <= r_base + ADDR_W'(r_offset[w_pop_tag]);
                r_wr_req_data <= w_wr_data;
            end
            if (w_ack) r_lines_done <= r_lines_done + 1'b1;
        end
    end

`ifdef CCI_MPF_STREAM_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else if (w_start_ok) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else if (w_busy) begin
            if (r_perf_cycles != '1) r_perf_cycles <= r_perf_cycles + 1'b1;
            if ((rd_almfull || wr_almfull) && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stall  = r_perf_stall;
`else
    assign perf_cycles = '0;
    assign perf_stall  = '0;
`endif

    assign rd_req_valid = r_rd_req_valid;
    assign rd_req_addr  = r_rd_req_addr;
    assign rd_req_tag   = r_rd_req_tag;
    assign wr_req_valid = r_wr_req_valid;
    assign wr_req_addr  = r_wr_req_addr;
    assign wr_req_data  = r_wr_req_data;
    assign busy         = w_busy;
    assign done         = (r_state == DONE);
    assign lines_done   = r_lines_done;
    assign dbg_state    = r_state;

    a_rsp_tag_live: assert property (@(posedge clk) disable iff (!reset_n)
        (rd_rsp_valid && w_busy) |-> r_slot_busy[rd_rsp_tag]);

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        w_rsp_push |-> (!w_fifo_full || w_pop));

endmodule

// File: doc/cci_mpf_stream_incr_afu.md
Name: cci_mpf_stream_incr_afu

Overview:
- Multi-line successor to the single-line read/increment/write AFU.
- Streams NUM_LINES cache lines from a host buffer and keeps up to MAX_OUTSTANDING reads in flight.
- Accepts out-of-order read responses, adds a programmable increment to every 64-bit lane, and writes each line back to its source address.
- Sits behind MPF, between the CSR manager and the c0/c1 request channels; reports busy/done and progress to CSRs.

Parameters:
- ADDR_W, 42, cache-line address width.
- DATA_W, 512, line width; must be a multiple of 64.
- MAX_OUTSTANDING, 16, read slots in flight; power of 2, at least 2.
- LEN_W, 16, width of the line-count field.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle CSR-write pulse.
- base_addr  in  ADDR_W  first line address; sampled on start.
- num_lines  in  LEN_W  line count; sampled on start.
- incr  in  64  per-lane addend; sampled on start.
- rd_req_valid  out  1  read request.
- rd_req_addr  out  ADDR_W  read request address.
- rd_req_tag  out  $clog2(MAX_OUTSTANDING)  mdata tag.
- rd_almfull  in  1  c0 almost-full.
- rd_rsp_valid  in  1  read response.
- rd_rsp_tag  in  $clog2(MAX_OUTSTANDING)  response tag.
- rd_rsp_data  in  DATA_W  response data.
- wr_req_valid  out  1  write request.
- wr_req_addr  out  ADDR_W  write request address.
- wr_req_data  out  DATA_W  write request data.
- wr_almfull  in  1  c1 almost-full.
- wr_ack_valid  in  1  write response.
- busy  out  1  run in progress.
- done  out  1  sticky completion flag.
- lines_done  out  LEN_W  acknowledged writes.

Behaviour:
- Reset values: every output is 0; state is IDLE; slot bitmap is all free; FIFO is empty.
- All request outputs are registered; no combinational path runs from any input to any output.
- FSM states:
  - IDLE: start moves to RUN; latches base_addr, num_lines and incr; clears done and lines_done. If num_lines==0, start goes to DONE instead.
  - RUN: issue reads; once issued==num_lines, go to DRAIN.
  - DRAIN: no new reads; once acks==num_lines, go to DONE.
  - DONE: done=1, busy=0. start behaves as in IDLE.
- start is ignored while busy (RUN or DRAIN).
- busy=1 exactly in RUN and DRAIN.
- Read issue: in RUN, issue one read per cycle when !rd_almfull, slot[tag] is free, and issued<num_lines.
  - tag = issued[tag bits]; addr = base+issued, wrapping mod 2^ADDR_W.
  - Record offset[tag]=issued and mark the slot busy. The next cycle's request uses the updated issued count.
- Read response: push {tag, data} into the response FIFO (depth MAX_OUTSTANDING; cannot overflow because slots bound occupancy).
  - A response whose tag has a free slot is a protocol error: assert in simulation, drop in hardware.
- Write issue: when the FIFO is non-empty and !wr_almfull, pop one entry per cycle.
  - wr_req_addr = base+offset[tag].
  - Each 64-bit lane i: data[i]+incr, mod 2^64 with no carry between lanes.
  - Free slot[tag] on the same cycle; a read may reuse that tag on the next cycle.
- Simultaneous response push and pop in the same cycle: both happen; FIFO occupancy is unchanged.
- wr_ack_valid increments lines_done (saturating at num_lines). Acks arriving in IDLE or DONE are ignored.
- reset_n low mid-run: everything aborts immediately to reset values. In-flight host responses after release are dropped (FIFO pushes gated to RUN/DRAIN).
- Throughput: 1 line/cycle steady state when neither channel is almost-full. Latency from response to write request: 2 cycles (FIFO plus output register).

Optional Feature:
- Macro: CCI_MPF_STREAM_PERF_EN.
- When defined, adds outputs perf_cycles[31:0] and perf_stall[31:0]:
  - perf_cycles counts cycles with busy=1.
  - perf_stall counts busy cycles where rd_almfull or wr_almfull is high.
  - Both clear on start, saturate at all-ones, and reset to 0.
- When not defined, both ports exist but are tied to 0 and the counters are not synthesised.

Decomposition:
- Package cci_mpf_stream_pkg holds:
  - t_stream_state enum (IDLE/RUN/DRAIN/DONE).
  - t_slot_tag.
  - LANE_W=64 and NUM_LANES=DATA_W/64.
  - lane-add function add_lanes(data, incr).
- Sub-module cci_mpf_stream_rsp_fifo: parametrised sync FIFO (width TAG+DATA_W, depth MAX_OUTSTANDING) with async active-low reset and notEmpty/full outputs.

Test Plan:
- Basic run: base=0x1000, num_lines=4, incr=1, in-order responses with lane0=5 -> writes to 0x1000..0x1003, lane0=6; done=1 and lines_done=4 after 4 acks.
- Reversed responses: num_lines=8 with responses returned in reverse tag order -> each write address matches the original read address; no lost or duplicate lines.
- Backpressure: hold rd_almfull for 10 cycles, then wr_almfull for 10 cycles -> no request asserted during either almfull; all 32 lines complete; FIFO never overflows.
- Edge cases:
  - num_lines=0 -> done 1 cycle after start with zero requests.
  - incr=0xFFFF_FFFF_FFFF_FFFF on lane data 1 -> lane wraps to 0 with no carry into the next lane.
- Slot limit and start while busy: MAX_OUTSTANDING=16, num_lines=40, responses withheld -> exactly 16 reads issued, then stall; a start pulse while busy is ignored.
- Mid-run reset: reset_n low after 5 of 20 lines -> all outputs 0; a subsequent start with num_lines=3 completes with lines_done=3.
